// File: rtl/queen_seq_ctrl.sv
// Sequencer between the pads and the N-queens solver core: collects and checks seed
// queens, launches the solver under a watchdog, then streams the per-column result.
module queen_seq_ctrl #(
  parameter int N       = 8,
  parameter int CW      = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_num,
  input  logic [2:0]      in_num,
  input  logic            in_valid,
  input  logic [CW-1:0]   col,
  input  logic [CW-1:0]   row,
  output logic            slv_start,
  output logic            slv_abort,
  output logic [N-1:0]    slv_fix_mask,
  output logic [N*CW-1:0] slv_fix_rows,
  input  logic            slv_wr_en,
  input  logic [CW-1:0]   slv_wr_col,
  input  logic [CW-1:0]   slv_wr_row,
  input  logic            slv_done,
  input  logic            slv_fail,
  output logic            out_valid,
  output logic [3:0]      out
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT, ERR} state_t;

  state_t          state, state_nxt;
  logic [2:0]      num, cnt;
  logic            conflict;
  logic [N-1:0]    row_used;
  logic [CW-1:0]   row_buf [N];
  logic [CW-1:0]   out_idx;
  logic [WW-1:0]   wdog;

  logic            col_hit, row_hit, beat_conflict, seed_take, load_last, wdog_expired;
  logic [CW-1:0]   buf_sel;

  // In IDLE the mask/row history belong to the previous job, so a beat
  // arriving with the strobe is only range-checked.
  always_comb begin : seed_check
    col_hit = 1'b0;
    row_hit = 1'b0;
    buf_sel = '0;
    for (int c = 0; c < N; c++) begin
      if (col == CW'(c) && slv_fix_mask[c]) col_hit = 1'b1;
      if (row == CW'(c) && row_used[c])     row_hit = 1'b1;
      if (out_idx == CW'(c))                buf_sel = row_buf[c];
    end
    if (state == IDLE) begin
      col_hit = 1'b0;
      row_hit = 1'b0;
    end
    beat_conflict = (col >= CW'(N)) || (row >= CW'(N)) || col_hit || row_hit;
    seed_take     = in_valid &&
                    ((state == IDLE && in_valid_num && in_num != 3'd0) ||
                     (state == LOAD && cnt != num));
    load_last     = (cnt + 3'd1 == num);
    wdog_expired  = (wdog == WW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin : fsm_next
    state_nxt = state;
    slv_start = 1'b0;
    slv_abort = 1'b0;
    out_valid = 1'b0;
    out       = 4'h0;
    case (state)
      IDLE: begin
        if (in_valid_num) state_nxt = (in_num == 3'd0) ? START : LOAD;
      end
      LOAD: begin
        if (cnt == num)
          state_nxt = conflict ? ERR : START;
        else if (in_valid && load_last)
          state_nxt = (conflict || beat_conflict) ? ERR : START;
      end
      START: begin
        slv_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A done in the expiry cycle still counts as a normal completion.
        if (slv_done) begin
          state_nxt = slv_fail ? ERR : OUT;
        end else if (wdog_expired) begin
          slv_abort = 1'b1;
          state_nxt = ERR;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        out       = 4'(buf_sel);
        if (out_idx == CW'(N - 1)) state_nxt = IDLE;
      end
      ERR: begin
        out_valid = 1'b1;
        out       = 4'hF;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath
    if (!rst_n) begin
      num          <= '0;
      cnt          <= '0;
      conflict     <= 1'b0;
      slv_fix_mask <= '0;
      slv_fix_rows <= '0;
      row_used     <= '0;
      out_idx      <= '0;
      wdog         <= '0;
      for (int c = 0; c < N; c++) row_buf[c] <= '0;
    end else begin
      if (state == IDLE && in_valid_num) begin
        num          <= in_num;
        cnt          <= '0;
        conflict     <= 1'b0;
        slv_fix_mask <= '0;
        slv_fix_rows <= '0;
        row_used     <= '0;
        for (int c = 0; c < N; c++) row_buf[c] <= '0;
      end
      // A seed landing on an already-fixed column keeps the first seed.
      if (seed_take) begin
        cnt <= (state == IDLE) ? 3'd1 : cnt + 3'd1;
        if (beat_conflict) conflict <= 1'b1;
        for (int c = 0; c < N; c++) begin
          if (col == CW'(c) && !col_hit) begin
            slv_fix_mask[c]           <= 1'b1;
            slv_fix_rows[c*CW +: CW]  <= row;
            row_buf[c]                <= row;
          end
          if (row == CW'(c)) row_used[c] <= 1'b1;
        end
      end
      if (state == START) begin
        wdog    <= '0;
        out_idx <= '0;
      end
      if (state == WAIT) begin
        wdog <= wdog + WW'(1);
        if (slv_wr_en) begin
          for (int c = 0; c < N; c++) begin
            if (slv_wr_col == CW'(c) && !slv_fix_mask[c]) row_buf[c] <= slv_wr_row;
          end
        end
      end
      if (state == OUT) out_idx <= out_idx + CW'(1);
    end
  end

endmodule
